// File: rtl/frame_byte_tx.sv
// Serialises a 32-bit frame stream into a byte stream for the host link:
// magic F0AA550F | size (2 B) | payload (MSB first) | 8-bit payload checksum.
module frame_byte_tx #(
  parameter logic [15:0] MAX_WORDS = 16'd4096,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_frame_ready,
  input  logic [15:0] i_frame_size,
  input  logic [31:0] i_in_data,
  input  logic        i_in_vld,
  output logic        o_in_rdy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_busy,
  output logic        o_frame_drop,
  output logic        o_size_err,
  output logic        o_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAGIC = 3'd1,
    ST_SIZE  = 3'd2,
    ST_WAITW = 3'd3,
    ST_BYTES = 3'd4,
    ST_CSUM  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic [15:0] size_r, size_s;
  logic [15:0] words_left_r, words_left_s;
  logic [15:0] stall_r, stall_s;
  logic [31:0] shift_r, shift_s;
  logic [7:0]  csum_r, csum_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic [7:0]  cur_byte_s;
  logic        tx_vld_r, tx_vld_s;
  logic        in_rdy_r, in_rdy_s;
  logic        busy_r;
  logic        drop_r, drop_s;
  logic        size_err_r, size_err_s;
  logic        underrun_r, underrun_s;
  logic        zero_fill_r, zero_fill_s;
  logic        prev_r;
  logic        rise_s;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'hF0;
      2'd1:    magic_byte = 8'hAA;
      2'd2:    magic_byte = 8'h55;
      default: magic_byte = 8'h0F;
    endcase
  endfunction

  assign rise_s = i_frame_ready & ~prev_r;

  // Byte to present next in the current emitting state; payload always leaves from shift_r[31:24]
  always_comb begin
    cur_byte_s = 8'h00;
    case (state_r)
      ST_MAGIC: cur_byte_s = magic_byte(idx_r);
      ST_SIZE: begin
        if (idx_r == 2'd0) cur_byte_s = size_r[15:8];
        else               cur_byte_s = size_r[7:0];
      end
      ST_BYTES: cur_byte_s = shift_r[31:24];
      ST_CSUM:  cur_byte_s = csum_r;
      default:  cur_byte_s = 8'h00;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    size_s       = size_r;
    words_left_s = words_left_r;
    stall_s      = stall_r;
    shift_s      = shift_r;
    csum_s       = csum_r;
    tx_data_s    = tx_data_r;
    tx_vld_s     = tx_vld_r;
    in_rdy_s     = in_rdy_r;
    size_err_s   = 1'b0;
    underrun_s   = underrun_r;
    zero_fill_s  = zero_fill_r;
    drop_s       = rise_s & (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s     = ST_MAGIC;
          idx_s       = 2'd0;
          csum_s      = 8'h00;
          underrun_s  = 1'b0;
          zero_fill_s = 1'b0;
          stall_s     = 16'd0;
          tx_vld_s    = 1'b1;
          tx_data_s   = 8'hF0;
          if (i_frame_size > MAX_WORDS) begin
            size_s     = MAX_WORDS;
            size_err_s = 1'b1;
          end else begin
            size_s     = i_frame_size;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAITW: begin
        if (in_rdy_r && i_in_vld) begin
          shift_s  = i_in_data;
          in_rdy_s = 1'b0;
          stall_s  = 16'd0;
          idx_s    = 2'd0;
          state_s  = ST_BYTES;
        end else if (zero_fill_r) begin
          shift_s  = 32'h0000_0000;
          in_rdy_s = 1'b0;
          idx_s    = 2'd0;
          state_s  = ST_BYTES;
        end else if (stall_r == TIMEOUT) begin
          // Source gave up: the rest of this frame is zero words without handshake
          underrun_s  = 1'b1;
          zero_fill_s = 1'b1;
          shift_s     = 32'h0000_0000;
          in_rdy_s    = 1'b0;
          idx_s       = 2'd0;
          state_s     = ST_BYTES;
        end else begin
          stall_s = stall_r + 16'd1;
        end
      end
      ST_MAGIC, ST_SIZE, ST_BYTES, ST_CSUM: begin
        if (!tx_vld_r) begin
          tx_vld_s  = 1'b1;
          tx_data_s = cur_byte_s;
        end else if (i_tx_rdy) begin
          tx_vld_s = 1'b0;
          idx_s    = idx_r + 2'd1;
          case (state_r)
            ST_MAGIC: begin
              if (idx_r == 2'd3) state_s = ST_SIZE;
              else               state_s = ST_MAGIC;
            end
            ST_SIZE: begin
              if (idx_r == 2'd1) begin
                idx_s        = 2'd0;
                words_left_s = size_r;
                if (size_r == 16'd0) begin
                  state_s = ST_CSUM;
                end else begin
                  state_s  = ST_WAITW;
                  in_rdy_s = ~zero_fill_r;
                end
              end else begin
                state_s = ST_SIZE;
              end
            end
            ST_BYTES: begin
              shift_s = {shift_r[23:0], 8'h00};
              csum_s  = csum_r + tx_data_r;
              if (idx_r == 2'd3) begin
                words_left_s = words_left_r - 16'd1;
                if (words_left_r == 16'd1) begin
                  state_s = ST_CSUM;
                end else begin
                  state_s  = ST_WAITW;
                  in_rdy_s = ~zero_fill_r;
                end
              end else begin
                state_s = ST_BYTES;
              end
            end
            default: begin
              state_s = ST_IDLE;
              idx_s   = 2'd0;
            end
          endcase
        end else begin
          tx_vld_s = 1'b1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tx_vld_s = 1'b0;
        in_rdy_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; edge detector resets high so a held frame_ready cannot start a frame
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      size_r       <= 16'd0;
      words_left_r <= 16'd0;
      stall_r      <= 16'd0;
      shift_r      <= 32'h0000_0000;
      csum_r       <= 8'h00;
      tx_data_r    <= 8'h00;
      tx_vld_r     <= 1'b0;
      in_rdy_r     <= 1'b0;
      busy_r       <= 1'b0;
      drop_r       <= 1'b0;
      size_err_r   <= 1'b0;
      underrun_r   <= 1'b0;
      zero_fill_r  <= 1'b0;
      prev_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      size_r       <= size_s;
      words_left_r <= words_left_s;
      stall_r      <= stall_s;
      shift_r      <= shift_s;
      csum_r       <= csum_s;
      tx_data_r    <= tx_data_s;
      tx_vld_r     <= tx_vld_s;
      in_rdy_r     <= in_rdy_s;
      busy_r       <= (state_s != ST_IDLE);
      drop_r       <= drop_s;
      size_err_r   <= size_err_s;
      underrun_r   <= underrun_s;
      zero_fill_r  <= zero_fill_s;
      prev_r       <= i_frame_ready;
    end
  end

  assign o_in_rdy     = in_rdy_r;
  assign o_tx_data    = tx_data_r;
  assign o_tx_vld     = tx_vld_r;
  assign o_busy       = busy_r;
  assign o_frame_drop = drop_r;
  assign o_size_err   = size_err_r;
  assign o_underrun   = underrun_r;

endmodule

// File: tb/tb_frame_byte_tx.sv
// Randomised bench for frame_byte_tx: expected byte streams come from a queue-based
// model of the wire format; sink/source are driven after posedge, sampled at negedge.
module tb_frame_byte_tx;

  localparam int MAXW = 4096;
  localparam int TMO  = 1024;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_ready = 1'b0;
  logic [15:0] i_frame_size = 16'd0;
  logic [31:0] i_in_data = 32'd0;
  logic        i_in_vld = 1'b0;
  logic        o_in_rdy;
  logic [7:0]  o_tx_data;
  logic        o_tx_vld;
  logic        i_tx_rdy = 1'b0;
  logic        o_busy;
  logic        o_frame_drop;
  logic        o_size_err;
  logic        o_underrun;

  always #5 sys_clk = ~sys_clk;

  frame_byte_tx dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_frame_ready(i_frame_ready), .i_frame_size(i_frame_size),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
    .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
    .o_busy(o_busy), .o_frame_drop(o_frame_drop), .o_size_err(o_size_err),
    .o_underrun(o_underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] words [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int n_supply, src_idx, acc_cnt, drop_cnt, serr_cnt, rdy_cnt, sink_mode, cyc;
  bit vld_rand, hold_pend, last_busy;
  logic [7:0] hold_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge sys_clk);
    if (hold_pend) check_eq("hold_stable", {o_tx_vld, o_tx_data}, {1'b1, hold_data});
    hold_pend = o_tx_vld && !i_tx_rdy;
    hold_data = o_tx_data;
    if (o_tx_vld && i_tx_rdy) got_q.push_back(o_tx_data);
    if (o_in_rdy && i_in_vld) begin
      acc_cnt++;
      src_idx++;
    end
    if (o_in_rdy) rdy_cnt++;
    if (o_frame_drop) drop_cnt++;
    if (o_size_err) serr_cnt++;
    last_busy = o_busy;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
    case (sink_mode)
      0:       i_tx_rdy = 1'b1;
      1:       i_tx_rdy = (cyc % 3 == 0);
      default: i_tx_rdy = ($urandom_range(0, 1) == 1);
    endcase
    i_in_vld  = (src_idx < n_supply) && (!vld_rand || $urandom_range(0, 1) == 1);
    i_in_data = (src_idx < n_supply) ? words[src_idx] : $urandom;
  endtask

  // Caller may preload words; missing ones are randomised.
  task automatic run_frame(input int size_in, input int supply, input int smode,
                           input bit vrand, input int drop_at);
    int sz, budget, n;
    logic [31:0] w;
    logic [7:0] b, sum;
    sz = (size_in > MAXW) ? MAXW : size_in;
    while (words.size() < sz) words.push_back($urandom);
    n_supply = supply; src_idx = 0; acc_cnt = 0; drop_cnt = 0; serr_cnt = 0; rdy_cnt = 0;
    sink_mode = smode; vld_rand = vrand;
    got_q.delete();
    exp_q = '{8'hF0, 8'hAA, 8'h55, 8'h0F};
    exp_q.push_back(8'((sz >> 8) & 255));
    exp_q.push_back(8'(sz & 255));
    sum = 8'd0;
    for (int i = 0; i < sz; i++) begin
      w = (i < supply) ? words[i] : 32'd0;
      for (int k = 3; k >= 0; k--) begin
        b = 8'((w >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        sum = 8'((int'(sum) + int'(b)) % 256);
      end
    end
    exp_q.push_back(sum);

    i_frame_size = 16'(size_in);
    i_frame_ready = 1'b1;
    step();
    sample();
    check_eq("first_byte", {o_tx_vld, o_tx_data}, {1'b1, 8'hF0});
    check_eq("size_err_at_start", o_size_err, (size_in > MAXW));
    check_eq("underrun_cleared", o_underrun, 1'b0);
    budget = 30 * sz + 3 * TMO + 200;
    n = 0;
    while (last_busy && n < budget) begin
      step();
      n++;
      i_frame_ready = (n < 3) || (drop_at > 0 && n >= drop_at && n < drop_at + 3);
      sample();
    end
    check_eq("frame_end_in_budget", last_busy, 1'b0);
    check_eq("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    check_eq("underrun", o_underrun, (supply < sz));
    check_eq("src_words", acc_cnt, supply);
    check_eq("drop_pulses", drop_cnt, (drop_at > 0));
    check_eq("size_err_pulses", serr_cnt, (size_in > MAXW));
    if (sz == 0) check_eq("no_in_rdy", rdy_cnt, 0);
    i_frame_ready = 1'b0;
    step();
    words.delete();
  endtask

  initial begin
    hold_pend = 1'b0; sink_mode = 0; n_supply = 0; src_idx = 0; cyc = 0; vld_rand = 1'b0;
    repeat (2) step();
    sample();
    check_eq("reset_outputs",
             {o_tx_vld, o_tx_data, o_in_rdy, o_busy, o_frame_drop, o_size_err, o_underrun}, 64'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // basic, empty, slow sink
    words = '{32'h01020304, 32'h0A0B0C0D};
    run_frame(2, 2, 0, 1'b0, 0);
    run_frame(0, 0, 0, 1'b0, 0);
    words = '{32'h01020304, 32'h0A0B0C0D};
    run_frame(2, 2, 1, 1'b0, 0);

    // underrun after first word; flag stays set while idle
    run_frame(3, 1, 0, 1'b0, 0);
    repeat (3) begin step(); sample(); end
    check_eq("underrun_sticky", {o_busy, o_underrun}, 2'b01);
    step();

    // overlap drop, then clamp
    run_frame(6, 6, 0, 1'b0, 20);
    run_frame(5000, MAXW, 0, 1'b0, 0);

    // randomised frames
    for (int f = 0; f < 6; f++) begin
      int s;
      s = $urandom_range(0, 10);
      run_frame(s, s, 2, 1'b1, 0);
    end

    // reset mid-payload with frame_ready held high
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    n_supply = 4; src_idx = 0; sink_mode = 0; vld_rand = 1'b0;
    i_frame_size = 16'd4;
    i_frame_ready = 1'b1;
    repeat (25) begin step(); sample(); end
    check_eq("busy_before_reset", o_busy, 1'b1);
    rst_n = 1'b0;
    n_supply = 0;
    step();
    hold_pend = 1'b0;
    sample();
    check_eq("reset_mid_frame",
             {o_tx_vld, o_tx_data, o_in_rdy, o_busy, o_frame_drop, o_size_err, o_underrun}, 64'd0);
    step();
    rst_n = 1'b1;
    repeat (10) begin
      step();
      sample();
      check_eq("no_restart_held_ready", {o_busy, o_tx_vld}, 2'b00);
    end
    i_frame_ready = 1'b0;
    words.delete();
    step();
    run_frame(3, 3, 2, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
